// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC owner and instruction fetch sequencer with output register, skid buffer, redirect and HLT stop.
// Optional perf counters enabled by defining PC_FETCH_PERF_EN.
module pc_fetch_ctrl #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              if_valid,
    output logic [15:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_fetch_cnt,
    output logic [CNT_W-1:0]  perf_redirect_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);
    typedef enum logic [2:0] {FETCH, WAIT, DRAIN, HPEND, HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] drain_addr;
    logic [ADDR_W-1:0] skid_pc;
    logic [15:0]       skid_instr;
    logic              skid_valid;
    logic              consume;
    logic              fire;
    logic              take;
    logic              capture;
    logic              is_hlt;

    // A request is only started with the skid empty, so every capture has room.
    assign imem_req  = ~rst & (((state == FETCH) & ~skid_valid) | (state == WAIT) | (state == DRAIN));
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign consume   = if_valid & ~stall;
    assign fire      = imem_req & imem_ack;
    assign take      = redirect & (state != HALT);
    assign capture   = fire & ~take & ((state == FETCH) | (state == WAIT));
    assign is_hlt    = imem_rdata[15:12] == 4'hF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= 16'h0000;
            if_pc      <= RESET_PC;
            skid_valid <= 1'b0;
            skid_instr <= 16'h0000;
            skid_pc    <= RESET_PC;
            halted     <= 1'b0;
        end else if (take) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            pc         <= {redirect_pc[ADDR_W-1:1], 1'b0};
            drain_addr <= (state == WAIT) ? pc : drain_addr;
            // An outstanding request must still complete; its data is dropped.
            state      <= (((state == WAIT) | (state == DRAIN)) & ~imem_ack) ? DRAIN : FETCH;
        end else begin
            if (capture & (~if_valid | consume)) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pc;
            end else if (consume) begin
                if_valid <= skid_valid;
                if_instr <= skid_instr;
                if_pc    <= skid_pc;
            end
            if (capture & if_valid & ~consume) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end else if (consume) begin
                skid_valid <= 1'b0;
            end
            if (capture)
                pc <= pc + ADDR_W'(2);
            case (state)
                FETCH:   state <= fire ? (is_hlt ? HPEND : FETCH) : (imem_req ? WAIT : FETCH);
                WAIT:    state <= imem_ack ? (is_hlt ? HPEND : FETCH) : WAIT;
                DRAIN:   state <= imem_ack ? FETCH : DRAIN;
                HPEND:   state <= (consume & ~skid_valid) ? HALT : HPEND;
                default: state <= HALT;
            endcase
            // The HLT word is the last one buffered; it is consumed once the skid is empty.
            halted <= halted | ((state == HPEND) & consume & ~skid_valid);
        end
    end

`ifdef PC_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            perf_fetch_cnt    <= perf_fetch_cnt + CNT_W'(capture & (perf_fetch_cnt != '1));
            perf_redirect_cnt <= perf_redirect_cnt + CNT_W'(take & (perf_redirect_cnt != '1));
            perf_stall_cnt    <= perf_stall_cnt + CNT_W'(if_valid & stall & (perf_stall_cnt != '1));
        end
    end
`endif
endmodule
